// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry_ctrl
// Purpose  : Debounces the scanned keypad code, turns each key press into a
//            single digit event and accumulates the digits into a saturating
//            binary number. The finished number is offered downstream on a
//            valid/ready handshake.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            key_value[3:0]   - scanned key code (0..9 digit, 4'hF none,
//                               4'hA..4'hE treated as none), asynchronous
//            commit           - single-cycle request to commit partial entry
//            clear            - single-cycle abort of entry or output
//            out_value        - committed number
//            out_valid        - out_value holds a committed number
//            out_ready        - consumer accepts out_value
//            digit_count      - digits collected in the current entry
//            overflow         - current or committed value saturated
//            echo_bcd         - (KEYPAD_ENTRY_ECHO_EN only) BCD echo of the
//                               entered digits, newest digit in low nibble,
//                               4'hF = blank
// Config   : define KEYPAD_ENTRY_ECHO_EN to add the echo_bcd output.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry_ctrl #(
  parameter int NUM_DIGITS      = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int VAL_W           = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       key_value,
  input  logic                             commit,
  input  logic                             clear,
  output logic [VAL_W-1:0]                 out_value,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
  output logic                             overflow
`ifdef KEYPAD_ENTRY_ECHO_EN
  ,
  output logic [4*NUM_DIGITS-1:0]          echo_bcd
`endif
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [3:0]       NO_KEY   = 4'hF;
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  // The accept decision is taken in the cycle whose increment lands the
  // counter on DEBOUNCE_CYCLES-1, so the event is visible one cycle earlier.
  localparam logic [DB_W-1:0]  DB_FIRE  = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_FIRE  = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
  localparam logic [VAL_W-1:0] VAL_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser and debouncer
  // --------------------------------------------------------------------------
  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      sync2_q, sync2_d;
  logic [3:0]      prev_q, prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pressed_q, pressed_d;

  logic [3:0]      w_code;
  logic            w_stable;
  logic            w_settle;
  logic            press_event;

  always_comb begin
    sync1_d   = key_value;
    sync2_d   = sync1_q;
    // Non-digit codes collapse onto "no key" before any comparison.
    w_code    = (sync2_q <= 4'd9) ? sync2_q : NO_KEY;
    prev_d    = w_code;
    w_stable  = (w_code == prev_q);
    db_cnt_d  = '0;
    if (w_stable) begin
      db_cnt_d = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + DB_W'(1);
    end
    w_settle    = w_stable && (db_cnt_q == DB_FIRE);
    press_event = w_settle && !pressed_q && (w_code != NO_KEY);
    pressed_d   = pressed_q;
    if (w_settle) begin
      if (!pressed_q && (w_code != NO_KEY)) begin
        pressed_d = 1'b1;
      end else if (pressed_q && (w_code == NO_KEY)) begin
        pressed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= NO_KEY;
      sync2_q   <= NO_KEY;
      prev_q    <= NO_KEY;
      db_cnt_q  <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      db_cnt_q  <= db_cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Entry FSM and accumulator
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [VAL_W-1:0] out_value_q, out_value_d;
  logic             out_valid_q, out_valid_d;

  logic [VAL_W+3:0] w_ext;
  logic [VAL_W+3:0] w_mac;
  logic             w_sat;
  logic             do_commit;

  // acc*10 + digit, computed four bits wider so saturation can be detected.
  // acc is always zero in IDLE, so the same datapath serves the first digit.
  always_comb begin
    w_ext = {4'b0000, acc_q};
    w_mac = (w_ext << 3) + (w_ext << 1) + {{VAL_W{1'b0}}, w_code};
    w_sat = |w_mac[VAL_W+3:VAL_W];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    to_d        = to_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    do_commit   = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (press_event) begin
            acc_d   = w_sat ? VAL_MAX : w_mac[VAL_W-1:0];
            ovf_d   = ovf_q | w_sat;
            cnt_d   = cnt_q + CNT_W'(1);
            to_d    = '0;
            state_d = COLLECT;
            // The digit lands first; a simultaneous commit then closes it.
            do_commit = (cnt_d == CNT_FULL) || commit;
          end else if (state_q == COLLECT) begin
            if (commit || (to_q == TO_FIRE)) begin
              do_commit = 1'b1;
            end else begin
              to_d = to_q + TO_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (do_commit) begin
      state_d     = HOLD;
      out_value_d = acc_d;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      to_q        <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_value   = out_value_q;
  assign out_valid   = out_valid_q;
  assign digit_count = cnt_q;
  assign overflow    = ovf_q;

`ifdef KEYPAD_ENTRY_ECHO_EN
  // --------------------------------------------------------------------------
  // BCD echo for the seven-segment display
  // --------------------------------------------------------------------------
  localparam int ECHO_W = 4 * NUM_DIGITS;

  logic [ECHO_W-1:0] echo_q, echo_d;

  always_comb begin
    echo_d = echo_q;
    if (clear) begin
      echo_d = '1;
    end else if (press_event && (state_q != HOLD)) begin
      // Shift form keeps NUM_DIGITS=1 legal (no negative slice bounds).
      echo_d = (echo_q << 4) | ECHO_W'(w_code);
    end else if ((state_q == HOLD) && out_valid_q && out_ready) begin
      echo_d = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_q <= '1;
    end else begin
      echo_q <= echo_d;
    end
  end

  assign echo_bcd = echo_q;
`endif

endmodule
`default_nettype wire
